serial_gate_reducer: RTL and testbench

//   Bit-serial logic-reduction stage. It sits downstream of the mux-built gate

---
 rtl/serial_gate_reducer.sv | 107 ++++++++++
 tb/tb_serial_gate_reducer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_gate_reducer.sv
// Bit-serial OR/AND/XOR reducer: folds a framed stream of single bits into one
// result per frame, with valid/ready on both sides and a one-entry result hold.
module serial_gate_reducer #(
  parameter  int MAX_BEATS = 16,
  localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             in_last,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_result,
  output logic [CNT_W-1:0] out_count,
  output logic             out_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [1:0]       OP_AND  = 2'b01;
  localparam logic [1:0]       OP_XOR  = 2'b10;
  localparam logic [1:0]       OP_RSVD = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);

  state_t           state, state_nxt;
  logic             acc, acc_nxt;
  logic [1:0]       op_q, op_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             err, err_nxt;
  logic             accept;

  // The reserved opcode folds as OR; its error is flagged on the first beat.
  function automatic logic fold(input logic [1:0] f_op, input logic a, input logic b);
    case (f_op)
      OP_AND:  return a & b;
      OP_XOR:  return a ^ b;
      default: return a | b;
    endcase
  endfunction

  // in_ready depends on registered state only, so out_ready never reaches it.
  assign in_ready   = (state != HOLD);
  assign accept     = in_valid && in_ready;
  assign out_valid  = (state == HOLD);
  assign out_result = acc;
  assign out_count  = cnt;
  assign out_err    = err;

  // NOTE: every next-state variable gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    op_nxt    = op_q;
    cnt_nxt   = cnt;
    err_nxt   = err;
    case (state)
      IDLE: begin
        if (accept) begin
          acc_nxt   = in_bit;
          op_nxt    = op;
          cnt_nxt   = CNT_W'(1);
          err_nxt   = (op == OP_RSVD);
          state_nxt = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_nxt = fold(op_q, acc, in_bit);
          if (cnt != CNT_MAX) cnt_nxt = cnt + 1'b1;
          err_nxt = err | (cnt == CNT_MAX);
          if (in_last) state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      acc   <= 1'b0;
      op_q  <= 2'b00;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      op_q  <= op_nxt;
      cnt   <= cnt_nxt;
      err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_serial_gate_reducer.sv
// Directed and randomized-gap bench for serial_gate_reducer, built with
// MAX_BEATS=4 so the overflow boundary is reachable with short frames.
module tb_serial_gate_reducer;

  localparam int MB = 4;
  localparam int CW = $clog2(MB + 1);
  localparam logic [1:0] OR_OP = 2'b00, AND_OP = 2'b01, XOR_OP = 2'b10, RSVD_OP = 2'b11;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0, in_bit = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [1:0]    op = 2'b00;
  logic          in_ready, out_valid, out_result, out_err;
  logic [CW-1:0] out_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_gate_reducer #(.MAX_BEATS(MB)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bit     (in_bit),
    .in_last    (in_last),
    .op         (op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_count  (out_count),
    .out_err    (out_err)
  );

  // Starts and ends on a falling edge. Beat i carries bits[i]; only beat 0
  // carries op_first, later beats carry op_rest (which must be ignored).
  task automatic send_frame(input logic [1:0] op_first, input logic [1:0] op_rest,
                            input int n, input logic [15:0] bits,
                            input bit last_en, input int gap_max);
    for (int i = 0; i < n; i++) begin
      int gap;
      int t;
      gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (gap) begin
        in_valid = 1'b0;
        in_bit   = 1'($urandom_range(1, 0));
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_bit   = bits[i];
      in_last  = last_en && (i == n - 1);
      op       = (i == 0) ? op_first : op_rest;
      t = 0;
      while (!in_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      checks++;
      if (t >= 100) begin
        errors++;
        $display("FAIL send_timeout: in_ready=%b required 1 for beat %0d", in_ready, i);
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Waits for a result, stalls out_ready for `stall` cycles while checking the
  // outputs stay put, then consumes it. got = {result, count, err}.
  task automatic collect(input int stall, output logic [CW+1:0] got);
    int t = 0;
    out_ready = 1'b0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL collect_timeout: out_valid=%b required 1", out_valid);
    end
    got = {out_result, out_count, out_err};
    repeat (stall) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_result, out_count, out_err} !== {1'b1, got}) begin
        errors++;
        $display("FAIL stall_stable: got %b required %b",
                 {out_valid, out_result, out_count, out_err}, {1'b1, got});
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, in_ready, out_result, out_count, out_err} !== {1'b0, 1'b1, 1'b0, CW'(0), 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got %b required %b",
               {out_valid, in_ready, out_result, out_count, out_err},
               {1'b0, 1'b1, 1'b0, CW'(0), 1'b0});
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_or_basic();
    out_ready = 1'b1;
    send_frame(OR_OP, OR_OP, 4, 16'b0100, 1'b1, 0);
    checks++;
    if ({out_valid, out_result, out_count, out_err} !== {1'b1, 1'b1, CW'(4), 1'b0}) begin
      errors++;
      $display("FAIL or_basic: got %b required %b",
               {out_valid, out_result, out_count, out_err}, {1'b1, 1'b1, CW'(4), 1'b0});
    end
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL or_one_cycle: valid/ready got %b required 01", {out_valid, in_ready});
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [CW+1:0] got;
    send_frame(AND_OP, AND_OP, 3, 16'b111, 1'b1, 0);
    collect(0, got);
    checks++;
    if (got !== {1'b1, CW'(3), 1'b0}) begin
      errors++;
      $display("FAIL b2b_and111: got %b required %b", got, {1'b1, CW'(3), 1'b0});
    end
    send_frame(AND_OP, AND_OP, 3, 16'b101, 1'b1, 0);
    collect(0, got);
    checks++;
    if (got !== {1'b0, CW'(3), 1'b0}) begin
      errors++;
      $display("FAIL b2b_and101: got %b required %b", got, {1'b0, CW'(3), 1'b0});
    end
    send_frame(XOR_OP, XOR_OP, 3, 16'b111, 1'b1, 0);
    collect(0, got);
    checks++;
    if (got !== {1'b1, CW'(3), 1'b0}) begin
      errors++;
      $display("FAIL b2b_xor111: got %b required %b", got, {1'b1, CW'(3), 1'b0});
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_frame(OR_OP, OR_OP, 1, 16'b0, 1'b1, 0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({in_ready, out_valid, out_result, out_count, out_err} !== {1'b0, 1'b1, 1'b0, CW'(1), 1'b0}) begin
        errors++;
        $display("FAIL hold_steady: cycle %0d got %b required %b", i,
                 {in_ready, out_valid, out_result, out_count, out_err},
                 {1'b0, 1'b1, 1'b0, CW'(1), 1'b0});
      end
      // A beat offered during HOLD must be ignored.
      in_valid = 1'b1;
      in_bit   = 1'b1;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL hold_release: valid/ready got %b required 01", {out_valid, in_ready});
    end
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [CW+1:0] got;
    send_frame(XOR_OP, XOR_OP, 6, 16'b111111, 1'b1, 0);
    collect(0, got);
    checks++;
    if (got !== {1'b0, CW'(4), 1'b1}) begin
      errors++;
      $display("FAIL overflow_xor6: got %b required %b", got, {1'b0, CW'(4), 1'b1});
    end
    send_frame(OR_OP, OR_OP, 2, 16'b10, 1'b1, 0);
    collect(0, got);
    checks++;
    if (got !== {1'b1, CW'(2), 1'b0}) begin
      errors++;
      $display("FAIL overflow_clear: got %b required %b", got, {1'b1, CW'(2), 1'b0});
    end
    send_frame(AND_OP, AND_OP, 4, 16'b1111, 1'b1, 0);
    collect(0, got);
    checks++;
    if (got !== {1'b1, CW'(4), 1'b0}) begin
      errors++;
      $display("FAIL exact_max: got %b required %b", got, {1'b1, CW'(4), 1'b0});
    end
  endtask

  task automatic test_op_handling();
    logic [CW+1:0] got;
    send_frame(RSVD_OP, RSVD_OP, 2, 16'b10, 1'b1, 0);
    collect(0, got);
    checks++;
    if (got !== {1'b1, CW'(2), 1'b1}) begin
      errors++;
      $display("FAIL reserved_op: got %b required %b", got, {1'b1, CW'(2), 1'b1});
    end
    send_frame(AND_OP, OR_OP, 3, 16'b101, 1'b1, 0);
    collect(0, got);
    checks++;
    if (got !== {1'b0, CW'(3), 1'b0}) begin
      errors++;
      $display("FAIL op_sticky: got %b required %b", got, {1'b0, CW'(3), 1'b0});
    end
  endtask

  task automatic test_reset_midframe();
    logic [CW+1:0] got;
    send_frame(OR_OP, OR_OP, 2, 16'b11, 1'b0, 0);
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, out_result, out_count, out_err} !== {1'b0, 1'b1, 1'b0, CW'(0), 1'b0}) begin
      errors++;
      $display("FAIL reset_midframe: got %b required %b",
               {out_valid, in_ready, out_result, out_count, out_err},
               {1'b0, 1'b1, 1'b0, CW'(0), 1'b0});
    end
    @(negedge clk);
    rst = 1'b1;
    send_frame(OR_OP, OR_OP, 1, 16'b1, 1'b1, 0);
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL reset_hold: valid/ready got %b required 01", {out_valid, in_ready});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: out_valid=%b required 0", out_valid);
    end
    send_frame(AND_OP, AND_OP, 2, 16'b11, 1'b1, 0);
    collect(0, got);
    checks++;
    if (got !== {1'b1, CW'(2), 1'b0}) begin
      errors++;
      $display("FAIL after_reset_and: got %b required %b", got, {1'b1, CW'(2), 1'b0});
    end
  endtask

  task automatic test_random_gaps();
    logic [CW+1:0] got;
    logic [CW+1:0] exp_v;
    logic [15:0]   bits;
    logic [1:0]    r_op;
    logic          e_acc;
    int            n;
    for (int f = 0; f < 25; f++) begin
      r_op = 2'($urandom_range(3, 0));
      n    = int'($urandom_range(6, 1));
      bits = 16'($urandom);
      e_acc = bits[0];
      for (int i = 1; i < n; i++) begin
        case (r_op)
          AND_OP:  e_acc = e_acc & bits[i];
          XOR_OP:  e_acc = e_acc ^ bits[i];
          default: e_acc = e_acc | bits[i];
        endcase
      end
      exp_v = {e_acc, CW'((n > MB) ? MB : n), (r_op == RSVD_OP) || (n > MB)};
      send_frame(r_op, 2'($urandom_range(3, 0)), n, bits, 1'b1, 2);
      collect(int'($urandom_range(3, 0)), got);
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL random_frame: frame %0d op=%b n=%0d got %b required %b",
                 f, r_op, n, got, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_or_basic();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_op_handling();
    test_reset_midframe();
    test_random_gaps();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
